uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

- Parametrised UART receiver for the debug-bus serial link.
- Frame format is set at elaboration: 5–9 data bits, optional odd/even parity, 1 or 2 stop bits.
- Samples each bit with a 3-sample majority vote at bit centre, and rejects false starts.
- Flags parity, framing and break conditions, and holds each received word in an output register with a valid/ready handshake and overrun reporting. It sits between the pad input and the command decoder.

## Interface
Parameters:
- CLK_FREQ, 25000000: clock frequency in Hz.
- BAUD, 115200: line rate. CPB = CLK_FREQ/BAUD (integer division); CPB ≥ 8 required, else elaboration error.
- DATA_BITS, 8: data bits per frame, 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- i_clk  in  1  the single clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_in  in  1  asynchronous serial line, idle high.
- o_data  out  DATA_BITS  received word, LSB = first data bit.
- o_valid  out  1  o_data and error flags are valid; held until accepted.
- i_ready  in  1  consumer accepts the word on a cycle where o_valid && i_ready.
- o_parity_err  out  1  parity mismatch for the held word (0 when PARITY = 0).
- o_frame_err  out  1  at least one stop bit sampled low for the held word.
- o_break  out  1  one-cycle pulse on a break frame.
- o_overrun  out  1  one-cycle pulse when a completed frame is dropped.
- o_busy  out  1  FSM not in IDLE.

## Operation
- i_in passes through a 2-flop synchronizer. Both flops reset to 1. The FSM uses only the synchronized line, rx.
- Let H = CPB/2. A bit counter runs 0..CPB-1 per bit window; windows are back to back.
- Each bit is sampled at counter values H-1, H and H+1. The bit value is the majority of the three samples, decided at H+1.
- FSM states:
  - WAIT_HI: entered on reset and after any framing error. Stays until rx = 1, then goes to IDLE.
  - IDLE: when rx = 0, clears the counter and goes to START.
  - START: if the start-bit majority is 1, this is a false start: return to IDLE with nothing reported. Otherwise go to DATA.
  - DATA: DATA_BITS windows. Each decided bit is shifted into position, LSB first.
  - PARITY: present only if PARITY ≠ 0. Expected bit gives odd (PARITY = 1) or even (PARITY = 2) total ones over data + parity bits.
  - STOP: STOP_BITS windows. Frame completes at the decision of the last stop bit.
- Frame completion with all stop bits 1: return to IDLE immediately, without waiting out the rest of the stop bit.
- Frame completion with any stop bit 0: go to WAIT_HI.
- Break frame: all data bits 0, parity bit 0 if present, and final stop bit 0.
  - o_break pulses for one cycle.
  - The word is not delivered and cannot cause an overrun.
- Delivery on a good or error frame: load o_data, o_parity_err and o_frame_err, and set o_valid. This happens when the output register is free, or when it is being accepted in that same cycle.
  - Otherwise the new frame is dropped, o_overrun pulses for one cycle, and the held word and flags stay unchanged.
- Acceptance (o_valid && i_ready) with no load in the same cycle clears o_valid. o_data and the error flags keep their values.

## Timing
- Reset values: o_valid 0, o_data 0, o_parity_err 0, o_frame_err 0, o_break 0, o_overrun 0, o_busy 1 (in WAIT_HI), counter 0.
- Edge 0 is the first rising edge at which i_in = 0 is captured.
  - FSM enters START at edge 2 with counter = 0.
  - With N = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS, o_valid rises at edge 2 + (N-1)·CPB + H + 2.
- o_break and o_overrun assert in the same cycle o_valid would have risen.
- o_valid may go high with i_ready already high. It is then accepted on the next edge.
- Back-to-back frames: the next start bit is detectable the cycle after the last stop-bit decision.
- Reset mid-frame: all state is discarded, the FSM enters WAIT_HI, and the line must read high before a start is accepted. A frame already in progress is therefore never partially received.

## Test plan
- 8N1, CPB = 16, i_ready = 1, send 0xA5 → o_valid for exactly one cycle at edge 156, o_data = 0xA5, all flags 0.
- 7E1, send 0x41 with a correct parity bit, then with parity flipped → o_data = 0x41 both times; o_parity_err 0 then 1.
- 8N2, i_ready = 0, send 0x11 then 0x22 → o_data stays 0x11, o_overrun pulses once. Raise i_ready → 0x11 accepted; the next frame 0x33 is delivered normally.
- Break frame (line low for 12 bit times, 8N1) → o_break pulse, o_valid stays 0, o_busy high until the line returns high. A following 0x5A is received correctly.
- Glitch: i_in low for CPB/4 cycles → no output, FSM back in IDLE. Single-cycle spike inside a data bit centre → bit value unaffected (majority).
- Assert i_rst mid-frame for 1 cycle → outputs at reset values. The remainder of the interrupted frame yields no o_valid. The next full frame 0xC3 is received.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// UART receiver with elaboration-time frame format, 3-sample majority voting,
// parity/framing/break detection and a valid/ready output register with overrun pulse.
module uart_rx_cfg #(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int unsigned CPB = CLK_FREQ / BAUD;
  localparam int unsigned H   = CPB / 2;
  localparam int unsigned CW  = $clog2(CPB);

  localparam logic [CW-1:0] CntLast = CW'(CPB - 1);
  localparam logic [CW-1:0] CntS0   = CW'(H - 1);
  localparam logic [CW-1:0] CntS1   = CW'(H);
  localparam logic [CW-1:0] CntDec  = CW'(H + 1);
  localparam logic [3:0]    DataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0]    StopLast = 4'(STOP_BITS - 1);

  if (CPB < 8) begin : g_cpb_chk
    $error("uart_rx_cfg: CLK_FREQ/BAUD must be at least 8");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_data_chk
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_par_chk
    $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_chk
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {StWaitHi, StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                 state_q, state_d;
  logic [1:0]             sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [1:0]             samp_q, samp_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_bit_q, par_bit_d;
  logic                   par_err_q, par_err_d;
  logic                   stop_err_q, stop_err_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   break_q, break_d;
  logic                   ovr_q, ovr_d;

  logic rx, maj, decide, accept, par_exp, is_break, frame_bad;

  assign rx = sync_q[1];

  always_comb begin
    state_d    = state_q;
    sync_d     = {sync_q[0], i_in};
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    samp_d     = samp_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    data_d     = data_q;
    valid_d    = valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    break_d    = 1'b0;
    ovr_d      = 1'b0;

    maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx) | (samp_q[1] & rx);
    decide    = (cnt_q == CntDec);
    accept    = valid_q & i_ready;
    par_exp   = (PARITY == 1) ? ~^shift_q : ^shift_q;
    frame_bad = stop_err_q | ~maj;
    // par_bit_q stays 0 when there is no parity bit, so it never blocks break detection
    is_break  = ~maj & (shift_q == '0) & ~par_bit_q;

    if (accept) valid_d = 1'b0;

    if (state_q inside {StStart, StData, StParity, StStop}) begin
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + 1'b1;
      if (cnt_q == CntS0) samp_d[0] = rx;
      if (cnt_q == CntS1) samp_d[1] = rx;
    end

    case (state_q)
      StWaitHi: if (rx) state_d = StIdle;
      StIdle: begin
        if (!rx) begin
          state_d    = StStart;
          cnt_d      = '0;
          idx_d      = '0;
          par_bit_d  = 1'b0;
          par_err_d  = 1'b0;
          stop_err_d = 1'b0;
        end
      end
      StStart: if (decide) state_d = maj ? StIdle : StData;
      StData: begin
        if (decide) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          idx_d   = idx_q + 1'b1;
          if (idx_q == DataLast) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? StParity : StStop;
          end
        end
      end
      StParity: begin
        if (decide) begin
          par_bit_d = maj;
          par_err_d = maj ^ par_exp;
          state_d   = StStop;
        end
      end
      StStop: begin
        if (decide) begin
          if (!maj) stop_err_d = 1'b1;
          idx_d = idx_q + 1'b1;
          if (idx_q == StopLast) begin
            state_d = frame_bad ? StWaitHi : StIdle;
            if (is_break) begin
              break_d = 1'b1;
            end else if (!valid_q || accept) begin
              data_d  = shift_q;
              perr_d  = par_err_q;
              ferr_d  = frame_bad;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StWaitHi;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= StWaitHi;
      sync_q     <= 2'b11;
      cnt_q      <= '0;
      idx_q      <= '0;
      samp_q     <= 2'b11;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      break_q    <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      samp_q     <= samp_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      stop_err_q <= stop_err_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      break_q    <= break_d;
      ovr_q      <= ovr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_break      = break_q;
  assign o_overrun    = ovr_q;
  assign o_busy       = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: three instances (8N1, 7E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_cfg;

  localparam int CPB = 16;

  typedef struct packed {
    logic [1:0] sel;
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line [3];
  logic rdy  [3];
  logic [7:0] d0;
  logic [6:0] d1;
  logic [7:0] d2;
  logic vld [3];
  logic perr [3];
  logic ferr [3];
  logic brk [3];
  logic ovr [3];
  logic busy [3];

  exp_t sb[$];
  int n_tests = 0;
  int n_fail = 0;
  int edge_cnt = 0;
  int t0_edge = 0;
  int rise_rel = -1;
  int hi_cnt0 = 0;
  int brk_cnt [3] = '{0, 0, 0};
  int ovr_cnt [3] = '{0, 0, 0};

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_in(line[0]), .o_data(d0), .o_valid(vld[0]), .i_ready(rdy[0]),
    .o_parity_err(perr[0]), .o_frame_err(ferr[0]), .o_break(brk[0]), .o_overrun(ovr[0]),
    .o_busy(busy[0])
  );
  uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_in(line[1]), .o_data(d1), .o_valid(vld[1]), .i_ready(rdy[1]),
    .o_parity_err(perr[1]), .o_frame_err(ferr[1]), .o_break(brk[1]), .o_overrun(ovr[1]),
    .o_busy(busy[1])
  );
  uart_rx_cfg #(.CLK_FREQ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u2 (
    .i_clk(clk), .i_rst(rst), .i_in(line[2]), .o_data(d2), .o_valid(vld[2]), .i_ready(rdy[2]),
    .o_parity_err(perr[2]), .o_frame_err(ferr[2]), .o_break(brk[2]), .o_overrun(ovr[2]),
    .o_busy(busy[2])
  );

  function automatic logic [8:0] get_data(input int s);
    case (s)
      0:       return {1'b0, d0};
      1:       return {2'b0, d1};
      default: return {1'b0, d2};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Drives one frame on line[s]; gbit selects a bit that gets a 1-cycle spike at its centre.
  task automatic send_frame(input int s, input logic [8:0] d, input int nb, input int par,
                            input int ns, input bit flip, input int gbit, input bit push_it);
    logic [15:0] v;
    logic [8:0]  dm;
    logic        p;
    int          n;
    exp_t        e;
    dm = d & ((9'h1 << nb) - 9'h1);
    v = '1;
    v[0] = 1'b0;
    for (int i = 0; i < nb; i++) v[1+i] = dm[i];
    n = 1 + nb;
    if (par != 0) begin
      p = (par == 1) ? ~^dm : ^dm;
      v[n] = p ^ flip;
      n++;
    end
    n += ns;
    if (push_it) begin
      e.sel  = 2'(s);
      e.data = dm;
      e.perr = (par != 0) && flip;
      e.ferr = 1'b0;
      sb.push_back(e);
    end
    @(negedge clk);
    t0_edge = edge_cnt;
    for (int k = 0; k < n; k++) begin
      for (int j = 0; j < CPB; j++) begin
        line[s] = (k == gbit && j == 9) ? ~v[k] : v[k];
        @(negedge clk);
      end
    end
    line[s] = 1'b1;
  endtask

  task automatic wait_idle(input int s);
    int k = 0;
    while (busy[s] && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", 32'(busy[s]), 32'd0);
  endtask

  task automatic set_ready(input int s, input logic r);
    @(posedge clk);
    #1 rdy[s] = r;
  endtask

  // Monitor: pops the scoreboard whenever a word is handed over, counts pulses.
  initial begin
    logic vprev0;
    exp_t e;
    vprev0 = 1'b0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) begin
        if (brk[s]) brk_cnt[s]++;
        if (ovr[s]) ovr_cnt[s]++;
        if (vld[s] && rdy[s]) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_word: dut %0d got 0x%0h, expected no word", s, get_data(s));
          end else begin
            e = sb.pop_front();
            chk("sb_dut", 32'(s), 32'(e.sel));
            chk("sb_data", 32'(get_data(s)), 32'(e.data));
            chk("sb_parity_err", 32'(perr[s]), 32'(e.perr));
            chk("sb_frame_err", 32'(ferr[s]), 32'(e.ferr));
          end
        end
      end
      if (vld[0] && !vprev0) rise_rel = edge_cnt - t0_edge - 1;
      if (vld[0]) hi_cnt0++;
      vprev0 = vld[0];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 3; s++) begin
      line[s] = 1'b1;
      rdy[s]  = 1'b1;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(vld[0]), 32'd0);
    chk("rst_data", 32'(d0), 32'd0);
    chk("rst_parity_err", 32'(perr[0]), 32'd0);
    chk("rst_frame_err", 32'(ferr[0]), 32'd0);
    chk("rst_break", 32'(brk[0]), 32'd0);
    chk("rst_overrun", 32'(ovr[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int s = 0; s < 3; s++) wait_idle(s);

    // 8N1 0xA5 latency and single-cycle valid
    send_frame(0, 9'h0A5, 8, 0, 1, 1'b0, -1, 1'b1);
    wait_idle(0);
    repeat (4) @(negedge clk);
    chk("a5_rise_edge", 32'(rise_rel), 32'd156);
    chk("a5_valid_cycles", 32'(hi_cnt0), 32'd1);

    // 7E1 good then flipped parity
    send_frame(1, 9'h041, 7, 2, 1, 1'b0, -1, 1'b1);
    send_frame(1, 9'h041, 7, 2, 1, 1'b1, -1, 1'b1);
    wait_idle(1);

    // 8N2 overrun with consumer stalled
    set_ready(2, 1'b0);
    send_frame(2, 9'h011, 8, 0, 2, 1'b0, -1, 1'b1);
    send_frame(2, 9'h022, 8, 0, 2, 1'b0, -1, 1'b0);
    repeat (4) @(negedge clk);
    chk("ovr_held_data", 32'(d2), 32'h11);
    chk("ovr_held_valid", 32'(vld[2]), 32'd1);
    chk("ovr_pulses", 32'(ovr_cnt[2]), 32'd1);
    set_ready(2, 1'b1);
    repeat (3) @(negedge clk);
    chk("ovr_drained", 32'(vld[2]), 32'd0);
    send_frame(2, 9'h033, 8, 0, 2, 1'b0, -1, 1'b1);
    wait_idle(2);

    // Break: line low for 12 bit times
    line[0] = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    chk("break_busy_low_line", 32'(busy[0]), 32'd1);
    chk("break_pulses", 32'(brk_cnt[0]), 32'd1);
    line[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("break_busy_released", 32'(busy[0]), 32'd0);
    send_frame(0, 9'h05A, 8, 0, 1, 1'b0, -1, 1'b1);
    wait_idle(0);

    // False start, then a spike on a data-bit centre
    line[0] = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    line[0] = 1'b1;
    repeat (20) @(negedge clk);
    chk("false_start_idle", 32'(busy[0]), 32'd0);
    send_frame(0, 9'h0A5, 8, 0, 1, 1'b0, 3, 1'b1);
    wait_idle(0);

    // Reset mid-frame with a word held
    set_ready(0, 1'b0);
    send_frame(0, 9'h03C, 8, 0, 1, 1'b0, -1, 1'b0);
    repeat (4) @(negedge clk);
    chk("held_valid", 32'(vld[0]), 32'd1);
    chk("held_data", 32'(d0), 32'h3C);
    fork
      send_frame(0, 9'h0F0, 8, 0, 1, 1'b0, -1, 1'b0);
      begin
        repeat (6 * CPB + 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", 32'(vld[0]), 32'd0);
        chk("midrst_data", 32'(d0), 32'd0);
        chk("midrst_frame_err", 32'(ferr[0]), 32'd0);
        chk("midrst_busy", 32'(busy[0]), 32'd1);
        rdy[0] = 1'b1;
      end
    join
    repeat (40) @(negedge clk);
    chk("midrst_no_word", 32'(vld[0]), 32'd0);
    send_frame(0, 9'h0C3, 8, 0, 1, 1'b0, -1, 1'b1);
    wait_idle(0);
    repeat (5) @(negedge clk);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("u0_overruns", 32'(ovr_cnt[0]), 32'd0);
    chk("u2_breaks", 32'(brk_cnt[2]), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
